branch_predictor_bht: RTL and testbench

//  Bimodal branch history table (BHT) of 2-bit saturating counters.

---
 rtl/branch_predictor_bht_pkg.sv | 33 +++
 rtl/branch_predictor_bht_sat_counter_2b.sv | 12 +
 rtl/branch_predictor_bht.sv | 139 +++++++++++++
 tb/tb_branch_predictor_bht.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_bht_pkg.sv
// Shared types for the bimodal branch history table: counter encoding, FSM
// states, the reset counter value and the saturating counter step.
package branch_pkg;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } bht_ctr_t;

    typedef enum logic {
        BHT_INIT = 1'b0,
        BHT_RUN  = 1'b1
    } bht_state_t;

    localparam bht_ctr_t BHT_RESET_CTR = WEAK_NT;

    // Saturating step: taken climbs toward STRONG_T, not-taken falls toward STRONG_NT.
    function automatic bht_ctr_t bht_next(input bht_ctr_t ctr, input logic taken);
        bht_ctr_t result;
        result = ctr;
        case (ctr)
            STRONG_NT: result = taken ? WEAK_NT  : STRONG_NT;
            WEAK_NT:   result = taken ? WEAK_T   : STRONG_NT;
            WEAK_T:    result = taken ? STRONG_T : WEAK_NT;
            STRONG_T:  result = taken ? STRONG_T : WEAK_T;
            default:   result = BHT_RESET_CTR;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/branch_predictor_bht_sat_counter_2b.sv
// Combinational next-state of a single 2-bit saturating predictor counter.
module sat_counter_2b
    import branch_pkg::*;
(
    input  bht_ctr_t i_ctr,
    input  logic     i_taken,
    output bht_ctr_t o_next
);

    assign o_next = bht_next(i_ctr, i_taken);

endmodule

// File: rtl/branch_predictor_bht.sv
// Bimodal BHT of 2-bit saturating counters with a self-clearing init sweep.
// Optional gshare indexing is enabled by defining BHT_GSHARE_EN.
module branch_predictor_bht
    import branch_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int INDEX_BITS = 6,
    parameter int HIST_BITS  = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            predict_valid,
    input  logic [XLEN-1:0] predict_pc,
    output logic            predict_taken,
    output logic            ready,
    input  logic            update_valid,
    input  logic [XLEN-1:0] update_pc,
    input  logic            update_taken,
    input  logic            update_mispredicted,
    output logic [31:0]     mispredict_count
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    bht_ctr_t              r_table [ENTRIES];
    bht_state_t            r_state;
    bht_state_t            w_nextState;
    logic [INDEX_BITS-1:0] r_initPtr;
    logic [31:0]           r_mispredictCount;

    logic [INDEX_BITS-1:0] w_predIdx;
    logic [INDEX_BITS-1:0] w_updIdx;
    logic [INDEX_BITS-1:0] w_ghrExt;
    bht_ctr_t              w_updCur;
    bht_ctr_t              w_updNext;
    logic                  w_run;
    logic                  w_updEn;
    logic                  w_wrEn;
    logic [INDEX_BITS-1:0] w_wrIdx;
    bht_ctr_t              w_wrData;
    logic                  w_unusedPcBits;

    assign w_run   = (r_state == BHT_RUN);
    assign w_updEn = w_run && update_valid;

`ifdef BHT_GSHARE_EN
    logic [HIST_BITS-1:0] r_ghr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ghr <= '0;
        end else if (w_updEn) begin
            r_ghr <= {r_ghr[HIST_BITS-2:0], update_taken};
        end
    end

    always_comb begin
        w_ghrExt                = '0;
        w_ghrExt[HIST_BITS-1:0] = r_ghr;
    end
`else
    assign w_ghrExt = '0;
`endif

    assign w_predIdx = predict_pc[INDEX_BITS+1:2] ^ w_ghrExt;
    assign w_updIdx  = update_pc[INDEX_BITS+1:2] ^ w_ghrExt;

    assign w_unusedPcBits = ^{predict_pc[XLEN-1:INDEX_BITS+2], predict_pc[1:0],
                              update_pc[XLEN-1:INDEX_BITS+2], update_pc[1:0]};

    assign w_updCur = r_table[w_updIdx];

    sat_counter_2b u_satCounter (
        .i_ctr   (w_updCur),
        .i_taken (update_taken),
        .o_next  (w_updNext)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= BHT_INIT;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            BHT_INIT: if (r_initPtr == INDEX_BITS'(ENTRIES - 1)) w_nextState = BHT_RUN;
            BHT_RUN:  w_nextState = BHT_RUN;
            default:  w_nextState = BHT_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_initPtr <= '0;
        end else if (r_state == BHT_INIT) begin
            r_initPtr <= r_initPtr + 1'b1;
        end
    end

    // Single write port: the init sweep owns it in INIT, the resolved branch in RUN.
    always_comb begin
        w_wrEn   = 1'b0;
        w_wrIdx  = w_updIdx;
        w_wrData = w_updNext;
        if (!reset) begin
            if (r_state == BHT_INIT) begin
                w_wrEn   = 1'b1;
                w_wrIdx  = r_initPtr;
                w_wrData = BHT_RESET_CTR;
            end else begin
                w_wrEn = update_valid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wrEn) begin
            r_table[w_wrIdx] <= w_wrData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mispredictCount <= '0;
        end else if (w_updEn && update_mispredicted && (r_mispredictCount != 32'hFFFF_FFFF)) begin
            r_mispredictCount <= r_mispredictCount + 32'd1;
        end
    end

    // Read-before-write: the prediction sees the table contents prior to this cycle's update.
    assign predict_taken    = w_run && predict_valid && r_table[w_predIdx][1];
    assign ready            = w_run;
    assign mispredict_count = r_mispredictCount;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Scoreboard bench for branch_predictor_bht: directed stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_branch_predictor_bht;

   logic        clk = 1'b0;
   logic        reset;
   logic        predict_valid;
   logic [31:0] predict_pc;
   logic        predict_taken;
   logic        ready;
   logic        update_valid;
   logic [31:0] update_pc;
   logic        update_taken;
   logic        update_mispredicted;
   logic [31:0] mispredict_count;

   typedef enum int {K_PRED, K_READY, K_COUNT} kind_t;

   typedef struct {
      string       name;
      kind_t       kind;
      logic [31:0] exp;
   } exp_t;

   exp_t expQ[$];
   int   vectors     = 0;
   int   miscompares = 0;

   // Free-running clock with a 10-unit period.
   always #5 clk = ~clk;

   branch_predictor_bht dut (
      .clk                 (clk),
      .reset               (reset),
      .predict_valid       (predict_valid),
      .predict_pc          (predict_pc),
      .predict_taken       (predict_taken),
      .ready               (ready),
      .update_valid        (update_valid),
      .update_pc           (update_pc),
      .update_taken        (update_taken),
      .update_mispredicted (update_mispredicted),
      .mispredict_count    (mispredict_count)
   );

   // Monitor: drains every expectation queued during the current cycle.
   always @(negedge clk) begin
      exp_t        e;
      logic [31:0] act;
      while (expQ.size() > 0) begin
         e = expQ.pop_front();
         case (e.kind)
            K_PRED:  act = {31'd0, predict_taken};
            K_READY: act = {31'd0, ready};
            default: act = mispredict_count;
         endcase
         vectors++;
         if (act !== e.exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", e.name, act, e.exp);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input kind_t kind, input logic [31:0] exp);
      exp_t e;
      e.name = name;
      e.kind = kind;
      e.exp  = exp;
      expQ.push_back(e);
   endtask

   task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic t, input logic m);
      update_valid        = v;
      update_pc           = pc;
      update_taken        = t;
      update_mispredicted = m;
      tick();
      update_valid        = 1'b0;
      update_mispredicted = 1'b0;
   endtask

   task automatic expectPredict(input string name, input logic [31:0] pc, input logic exp);
      predict_valid = 1'b1;
      predict_pc    = pc;
      checkOutput(name, K_PRED, {31'd0, exp});
      tick();
      predict_valid = 1'b0;
   endtask

   task automatic runInit(input logic updDuringInit);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      if (updDuringInit) begin
         update_valid        = 1'b1;
         update_pc           = 32'h100;
         update_taken        = 1'b1;
         update_mispredicted = 1'b1;
      end
      for (int i = 1; i <= 64; i++) begin
         checkOutput($sformatf("ready_init_c%0d", i), K_READY, 32'd0);
         if (i == 1) checkOutput("pred_in_init", K_PRED, 32'd0);
         tick();
      end
      update_valid        = 1'b0;
      update_mispredicted = 1'b0;
      checkOutput("ready_c65", K_READY, 32'd1);
      tick();
   endtask

   // Watchdog: aborts the run if the directed sequence hangs.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence: init timing, training, aliasing, read-before-write, re-init, gshare.
   initial begin
      reset               = 1'b0;
      predict_valid       = 1'b1;
      predict_pc          = 32'h100;
      update_valid        = 1'b0;
      update_pc           = 32'h0;
      update_taken        = 1'b0;
      update_mispredicted = 1'b0;
      tick();

      runInit(1'b0);
      expectPredict("reset_pred_100", 32'h100, 1'b0);
      checkOutput("reset_count", K_COUNT, 32'd0);
      tick();

`ifndef BHT_GSHARE_EN
      applyStimulus(1'b1, 32'h100, 1'b1, 1'b0);
      expectPredict("train_T1", 32'h100, 1'b1);
      applyStimulus(1'b1, 32'h100, 1'b1, 1'b1);
      expectPredict("train_T2", 32'h100, 1'b1);
      predict_valid = 1'b0;
      predict_pc    = 32'h100;
      checkOutput("pred_valid_low", K_PRED, 32'd0);
      tick();
      applyStimulus(1'b1, 32'h100, 1'b0, 1'b1);
      applyStimulus(1'b1, 32'h100, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h100, 1'b0, 1'b1);
      expectPredict("train_N3", 32'h100, 1'b0);
      applyStimulus(1'b1, 32'h100, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h100, 1'b1, 1'b0);
      applyStimulus(1'b1, 32'h100, 1'b1, 1'b0);
      expectPredict("floor_sat", 32'h100, 1'b1);
      applyStimulus(1'b0, 32'h100, 1'b0, 1'b1);
      expectPredict("no_upd_when_invalid", 32'h100, 1'b1);
      checkOutput("count_3", K_COUNT, 32'd3);
      tick();

      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'h180, 1'b1, 1'b1);
      applyStimulus(1'b1, 32'h180, 1'b0, 1'b0);
      expectPredict("ceil_sat_then_N", 32'h180, 1'b1);
      applyStimulus(1'b1, 32'h180, 1'b0, 1'b0);
      expectPredict("ceil_sat_then_NN", 32'h180, 1'b0);
      checkOutput("count_8", K_COUNT, 32'd8);
      tick();

      applyStimulus(1'b1, 32'h100, 1'b1, 1'b0);
      applyStimulus(1'b1, 32'h100, 1'b1, 1'b0);
      expectPredict("alias_200", 32'h200, 1'b1);
      expectPredict("neighbor_104", 32'h104, 1'b0);

      predict_valid = 1'b1;
      predict_pc    = 32'h40;
      update_valid  = 1'b1;
      update_pc     = 32'h40;
      update_taken  = 1'b1;
      checkOutput("rbw_same_cycle", K_PRED, 32'd0);
      tick();
      update_valid  = 1'b0;
      checkOutput("rbw_next_cycle", K_PRED, 32'd1);
      tick();
      predict_valid = 1'b0;
`endif

      reset = 1'b1;
      tick();
      reset               = 1'b0;
      update_valid        = 1'b1;
      update_pc           = 32'h100;
      update_taken        = 1'b1;
      update_mispredicted = 1'b1;
      for (int i = 0; i < 29; i++) tick();
      runInit(1'b1);
      expectPredict("reinit_100", 32'h100, 1'b0);
      expectPredict("reinit_40", 32'h40, 1'b0);
      expectPredict("reinit_180", 32'h180, 1'b0);
      checkOutput("reinit_count", K_COUNT, 32'd0);
      tick();

`ifndef BHT_GSHARE_EN
      applyStimulus(1'b1, 32'h40, 1'b1, 1'b0);
      expectPredict("reinit_weak_40", 32'h40, 1'b1);
      applyStimulus(1'b1, 32'h100, 1'b1, 1'b0);
      expectPredict("reinit_weak_100", 32'h100, 1'b1);
`else
      applyStimulus(1'b1, 32'h100, 1'b1, 1'b0);
      applyStimulus(1'b1, 32'h100, 1'b1, 1'b0);
      applyStimulus(1'b1, 32'h100, 1'b0, 1'b0);
      expectPredict("gs_pc18_e0", 32'h18, 1'b1);
      expectPredict("gs_pc0_e6", 32'h0, 1'b0);
      expectPredict("gs_pc4_e7", 32'h4, 1'b0);
      expectPredict("gs_pc14_e3", 32'h14, 1'b0);
      expectPredict("gs_pc1c_e1", 32'h1C, 1'b1);
`endif

      tick();
      tick();
      if (expQ.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL queue_drained: got %0d pending, expected 0", expQ.size());
      end
      if (vectors < 12) begin
         miscompares++;
         $display("[TB] FAIL vector_count: got %0d, expected at least 12", vectors);
      end
      $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      if (miscompares == 0) begin
         $display("[TB] PASS");
      end else begin
         $display("[TB] FAIL %0d miscompares", miscompares);
      end
      $finish;
   end

endmodule
